// File: rtl/rotary_pkg.sv
// rotary_pkg: shared types and constants for the rotary encoder decoder.
package rotary_pkg;
    typedef enum logic [2:0] {REST, CW1, CW2, CW3, CCW1, CCW2, CCW3, LOST} state_t;
    localparam logic DIR_CW = 1'b1;
    localparam logic DIR_CCW = 1'b0;
    localparam logic [1:0] AB_REST = 2'b11;
    // A/B code a state expects to be sitting on; LOST has no code and maps to rest
    function automatic logic [1:0] state_code(input state_t s);
        return (s == CW1 || s == CCW3) ? 2'b01 :
               (s == CW2 || s == CCW2) ? 2'b00 :
               (s == CW3 || s == CCW1) ? 2'b10 : AB_REST;
    endfunction
endpackage

// File: rtl/quad_step_fsm.sv
// quad_step_fsm: Gray-code detent tracker; flags completed detents and illegal A/B jumps.
module quad_step_fsm
    import rotary_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] ab,
    output logic       step,
    output logic       step_dir,
    output logic       illegal
);
    state_t state;
    state_t next;
    always_comb begin
        // both bits flipping is illegal, except the 00 -> 11 abort from mid-detent
        illegal = state != LOST && ab != AB_REST && (ab ^ state_code(state)) == 2'b11;
        step = !illegal && ab == AB_REST && (state == CW3 || state == CCW3);
        step_dir = state == CW3 ? DIR_CW : DIR_CCW;
        next = state;
        if (illegal)
            next = LOST;
        else
            case (state)
                REST: next = ab == 2'b01 ? CW1 : ab == 2'b10 ? CCW1 : REST;
                CW1:  next = ab == 2'b00 ? CW2 : ab == AB_REST ? REST : CW1;
                CW2:  next = ab == 2'b10 ? CW3 : ab == 2'b01 ? CW1 : ab == AB_REST ? REST : CW2;
                CW3:  next = ab == AB_REST ? REST : ab == 2'b00 ? CW2 : CW3;
                CCW1: next = ab == 2'b00 ? CCW2 : ab == AB_REST ? REST : CCW1;
                CCW2: next = ab == 2'b01 ? CCW3 : ab == 2'b10 ? CCW1 : ab == AB_REST ? REST : CCW2;
                CCW3: next = ab == AB_REST ? REST : ab == 2'b00 ? CCW2 : CCW3;
                default: next = ab == AB_REST ? REST : LOST;
            endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            state <= REST;
        else
            state <= next;
endmodule

// File: rtl/rotary_decoder.sv
// rotary_decoder: quadrature decoder with bounded position, button clear and error ticks.
// Define ROTARY_SAT_EN to saturate pos at 0/MAX instead of wrapping.
module rotary_decoder
    import rotary_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MAX = 99
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_db,
    input  logic             b_db,
    input  logic             btn_db,
    output logic [WIDTH-1:0] pos,
    output logic             step_tick,
    output logic             dir,
    output logic             btn_tick,
    output logic             err_tick
);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
`ifdef ROTARY_SAT_EN
    localparam logic [WIDTH-1:0] PAST_MAX = MAX_W;
    localparam logic [WIDTH-1:0] PAST_ZERO = '0;
`else
    localparam logic [WIDTH-1:0] PAST_MAX = '0;
    localparam logic [WIDTH-1:0] PAST_ZERO = MAX_W;
`endif
    logic step;
    logic step_dir;
    logic illegal;
    logic btn_prev;
    logic btn_edge;
    logic [WIDTH-1:0] pos_next;
    quad_step_fsm u_fsm (
        .clk     (clk),
        .reset_n (reset_n),
        .ab      ({a_db, b_db}),
        .step    (step),
        .step_dir(step_dir),
        .illegal (illegal)
    );
    assign btn_edge = btn_db & ~btn_prev;
    // button clear takes priority over a coincident step
    always_comb begin
        pos_next = pos;
        if (btn_edge)
            pos_next = '0;
        else if (step)
            pos_next = step_dir == DIR_CW ? (pos == MAX_W ? PAST_MAX : pos + WIDTH'(1))
                                          : (pos == '0 ? PAST_ZERO : pos - WIDTH'(1));
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            pos <= '0;
            dir <= DIR_CCW;
            step_tick <= 1'b0;
            btn_tick <= 1'b0;
            err_tick <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            pos <= pos_next;
            dir <= step ? step_dir : dir;
            step_tick <= step;
            btn_tick <= btn_edge;
            err_tick <= illegal;
            btn_prev <= btn_db;
        end
endmodule

// File: tb/tb_rotary_decoder.sv
// tb_rotary_decoder: table-driven directed checks of rotary_decoder (wrap or ROTARY_SAT_EN build).
module tb_rotary_decoder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic a_db = 1'b1;
    logic b_db = 1'b1;
    logic btn_db = 1'b0;
    logic [7:0] pos;
    logic step_tick;
    logic dir;
    logic btn_tick;
    logic err_tick;
    int n_checks = 0;
    int n_fail = 0;
`ifdef ROTARY_SAT_EN
    localparam logic [7:0] UP_AT_MAX = 8'd99;
    localparam logic [7:0] DN_AT_ZERO = 8'd0;
`else
    localparam logic [7:0] UP_AT_MAX = 8'd0;
    localparam logic [7:0] DN_AT_ZERO = 8'd99;
`endif
    typedef struct {
        logic [1:0] ab;
        logic       btn;
        int         hold;
        logic       step;
        logic       dir;
        logic       btnt;
        logic       err;
        logic [7:0] pos;
    } vec_t;
    vec_t v[49];
    rotary_decoder #(.WIDTH(8), .MAX(99)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .a_db     (a_db),
        .b_db     (b_db),
        .btn_db   (btn_db),
        .pos      (pos),
        .step_tick(step_tick),
        .dir      (dir),
        .btn_tick (btn_tick),
        .err_tick (err_tick)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask
    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            a_db = v[i].ab[1];
            b_db = v[i].ab[0];
            btn_db = v[i].btn;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d step_tick", i), int'(step_tick), int'(v[i].step));
            chk($sformatf("v%0d dir", i), int'(dir), int'(v[i].dir));
            chk($sformatf("v%0d btn_tick", i), int'(btn_tick), int'(v[i].btnt));
            chk($sformatf("v%0d err_tick", i), int'(err_tick), int'(v[i].err));
            chk($sformatf("v%0d pos", i), int'(pos), int'(v[i].pos));
            for (int k = 1; k < v[i].hold; k++) begin
                @(posedge clk);
                #1;
                chk($sformatf("v%0d hold ticks", i), int'({step_tick, btn_tick, err_tick}), 0);
                chk($sformatf("v%0d hold pos", i), int'(pos), int'(v[i].pos));
                chk($sformatf("v%0d hold dir", i), int'(dir), int'(v[i].dir));
            end
        end
    endtask
    task automatic cw_detents(input int n, input int exp_pos);
        logic [1:0] seq[4];
        seq = '{2'b01, 2'b00, 2'b10, 2'b11};
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 4; j++) begin
                a_db = seq[j][1];
                b_db = seq[j][0];
                @(posedge clk);
                #1;
            end
        chk($sformatf("after %0d CW detents pos", n), int'(pos), exp_pos);
        chk($sformatf("after %0d CW detents dir", n), int'(dir), 1);
    endtask
    initial begin
        // CW from reset
        v[0]  = '{2'b01, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        v[1]  = '{2'b00, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        v[2]  = '{2'b10, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        v[3]  = '{2'b11, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        // CCW from 5
        v[4]  = '{2'b10, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};
        v[5]  = '{2'b00, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};
        v[6]  = '{2'b01, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};
        v[7]  = '{2'b11, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4};
        // partial reversal, then a full CW detent proves the FSM is back at rest
        v[8]  = '{2'b01, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};
        v[9]  = '{2'b00, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};
        v[10] = '{2'b01, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};
        v[11] = '{2'b11, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};
        v[12] = '{2'b01, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};
        v[13] = '{2'b00, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};
        v[14] = '{2'b10, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};
        v[15] = '{2'b11, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5};
        // illegal jump to LOST, recovery, then normal counting
        v[16] = '{2'b00, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5};
        v[17] = '{2'b10, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};
        v[18] = '{2'b11, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};
        v[19] = '{2'b01, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};
        v[20] = '{2'b00, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};
        v[21] = '{2'b10, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5};
        v[22] = '{2'b11, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd6};
        // CW at MAX, button clear, CCW at zero, button clear
        v[23] = '{2'b01, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd99};
        v[24] = '{2'b00, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd99};
        v[25] = '{2'b10, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd99};
        v[26] = '{2'b11, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, UP_AT_MAX};
        v[27] = '{2'b11, 1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0};
        v[28] = '{2'b11, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        v[29] = '{2'b10, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        v[30] = '{2'b00, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        v[31] = '{2'b01, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        v[32] = '{2'b11, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, DN_AT_ZERO};
        v[33] = '{2'b11, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        v[34] = '{2'b11, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        // button edge coincident with a completing CW detent at pos 7
        v[35] = '{2'b01, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7};
        v[36] = '{2'b00, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7};
        v[37] = '{2'b10, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7};
        v[38] = '{2'b11, 1'b1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
        v[39] = '{2'b11, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        // into CW2, then reset
        v[40] = '{2'b01, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        v[41] = '{2'b00, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        // after release on AB=00: rest sees an illegal jump, must recover via 11
        v[42] = '{2'b00, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        v[43] = '{2'b10, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        v[44] = '{2'b11, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        v[45] = '{2'b01, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        v[46] = '{2'b00, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        v[47] = '{2'b10, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        v[48] = '{2'b11, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset pos", int'(pos), 0);
        chk("reset dir", int'(dir), 0);
        chk("reset step_tick", int'(step_tick), 0);
        chk("reset btn_tick", int'(btn_tick), 0);
        chk("reset err_tick", int'(err_tick), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        apply(0, 3);
        cw_detents(4, 5);
        apply(4, 22);
        cw_detents(93, 99);
        apply(23, 34);
        cw_detents(7, 7);
        apply(35, 39);
        cw_detents(1, 1);
        apply(40, 41);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset pos", int'(pos), 0);
        chk("async reset dir", int'(dir), 0);
        chk("async reset ticks", int'({step_tick, btn_tick, err_tick}), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply(42, 48);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
